dropout_rescaler: RTL and testbench

DROPOUT_RESCALER -- requirements
Module: dropout_rescaler

---
 rtl/dropout_rescaler.sv | 177 +++++++++++++++++
 tb/tb_dropout_rescaler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dropout_rescaler.sv
// dropout_rescaler: applies a dropout mask and 2^DROP_SHIFT rescaling to a
// stream of 8-bit activations grouped in frames of FRAME elements. The
// training/bypass mode is latched once per frame. Per-frame kept statistics
// and a saturating clip counter are also maintained.
module dropout_rescaler #(
  parameter int DROP_SHIFT = 1,
  parameter int FRAME      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_keep,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_done,
  output logic [3:0] frame_kept,
  output logic [7:0] sat_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [3:0] LAST_IDX = 4'(FRAME - 1);

  // Widen before shifting so that bits pushed past bit 7 remain visible.
  function automatic logic [15:0] shift_up(input logic [7:0] d);
    return {8'h00, d} << DROP_SHIFT;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  kept_cnt_q, kept_cnt_d;
  logic        frame_mode_q, frame_mode_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  frame_kept_q, frame_kept_d;
  logic [7:0]  sat_count_q, sat_count_d;

  logic        in_ready_s;
  logic        accept_s;
  logic        mode_s;
  logic [15:0] wide_s;
  logic        sat_s;
  logic        kept_s;
  logic        last_s;
  logic [7:0]  elem_s;
  logic [3:0]  kept_sum_s;

  assign in_ready_s = !out_valid_q || out_ready;
  assign accept_s   = in_valid && in_ready_s;

  // Datapath: effective mode for this element, scaling, saturation and keep decision.
  always_comb begin
    // The first element of a frame sees ena directly; it is latched at that point.
    if (state_q == IDLE) begin
      mode_s = ena;
    end else begin
      mode_s = frame_mode_q;
    end
    wide_s     = shift_up(in_data);
    sat_s      = mode_s && in_keep && (wide_s[15:8] != 8'h00);
    kept_s     = !mode_s || in_keep;
    last_s     = (idx_q == LAST_IDX);
    kept_sum_s = kept_cnt_q + {3'b000, kept_s};
    if (!mode_s) begin
      elem_s = in_data;
    end else if (!in_keep) begin
      elem_s = 8'h00;
    end else if (sat_s) begin
      elem_s = 8'hFF;
    end else begin
      elem_s = wide_s[7:0];
    end
  end

  // Next-state: frame FSM, output register, statistics and clip counter.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    kept_cnt_d   = kept_cnt_q;
    frame_mode_d = frame_mode_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    frame_kept_d = frame_kept_q;
    sat_count_d  = sat_count_q;

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = elem_s;
      out_last_d  = last_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (accept_s) begin
      case (state_q)
        IDLE: begin
          frame_mode_d = ena;
          state_d      = last_s ? IDLE : ACTIVE;
        end
        ACTIVE: begin
          state_d = last_s ? IDLE : ACTIVE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (accept_s && last_s) begin
      idx_d        = 4'd0;
      kept_cnt_d   = 4'd0;
      frame_kept_d = kept_sum_s;
      frame_done_d = 1'b1;
    end else if (accept_s) begin
      idx_d      = idx_q + 4'd1;
      kept_cnt_d = kept_sum_s;
    end else begin
      idx_d      = idx_q;
      kept_cnt_d = kept_cnt_q;
    end

    if (accept_s && sat_s && (sat_count_q != 8'hFF)) begin
      sat_count_d = sat_count_q + 8'd1;
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      kept_cnt_q   <= 4'd0;
      frame_mode_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_kept_q <= 4'd0;
      sat_count_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      kept_cnt_q   <= kept_cnt_d;
      frame_mode_q <= frame_mode_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      frame_kept_q <= frame_kept_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign frame_kept = frame_kept_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_dropout_rescaler.sv
// Bench for dropout_rescaler: directed scenarios plus random traffic,
// checked every cycle against an arithmetic reference model.
module tb_dropout_rescaler;

  localparam int S  = 1;
  localparam int FR = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_keep = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_done;
  logic [3:0] frame_kept;
  logic [7:0] sat_count;

  dropout_rescaler #(.DROP_SHIFT(S), .FRAME(FR)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_done(frame_done), .frame_kept(frame_kept), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int dq[$];
  bit lq[$];
  int pos = 0;
  bit mode = 1'b0;
  int kept = 0;
  int sat_m = 0;
  bit exp_done = 1'b0;
  int exp_kept = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; model advances on the same handshake rules.
  task automatic step(input bit v, input logic [7:0] d, input bit k, input bit e, input bit r);
    bit exp_rdy, acc, outx;
    int p, val;
    in_valid = v; in_data = d; in_keep = k; ena = e; out_ready = r;
    #4;
    exp_rdy = (dq.size() == 0) || r;
    chk("in_ready", in_ready, exp_rdy);
    acc  = v && exp_rdy;
    outx = (dq.size() != 0) && r;
    @(posedge clk);
    #1;
    if (outx) begin
      void'(dq.pop_front());
      void'(lq.pop_front());
    end
    exp_done = 1'b0;
    if (acc) begin
      if (pos == 0) mode = e;
      p = int'(d) * (1 << S);
      if (!mode) val = d;
      else if (!k) val = 0;
      else val = (p > 255) ? 255 : p;
      if (mode && k && p > 255 && sat_m < 255) sat_m++;
      if (!mode || k) kept++;
      dq.push_back(val);
      lq.push_back(pos == FR - 1);
      if (pos == FR - 1) begin
        exp_done = 1'b1;
        exp_kept = kept;
        kept = 0;
        pos = 0;
      end else begin
        pos++;
      end
    end
    chk("out_valid", out_valid, dq.size() != 0);
    if (dq.size() != 0) begin
      chk("out_data", out_data, dq[0]);
      chk("out_last", out_last, lq[0]);
    end
    chk("frame_done", frame_done, exp_done);
    chk("frame_kept", frame_kept, exp_kept);
    chk("sat_count", sat_count, sat_m);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_kept", frame_kept, 0);
    chk("rst_sat_count", sat_count, 0);
    dq.delete(); lq.delete();
    pos = 0; mode = 1'b0; kept = 0; sat_m = 0; exp_done = 1'b0; exp_kept = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] v24 [8];
    bit         k24 [8];
    v24[0] = 8'h80; v24[1] = 8'h7F; v24[2] = 8'h05;
    k24[0] = 1'b1;  k24[1] = 1'b1;  k24[2] = 1'b1;
    for (int i = 3; i < 8; i++) begin
      v24[i] = 8'(8'h40 + i);
      k24[i] = 1'b0;
    end

    #2;
    do_reset();

    // full-keep training frame
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b1, 1'b1, 1'b1);
      if (i == 7) begin
        chk("f23_last_data", out_data, 8'h2E);
        chk("f23_last_flag", out_last, 1'b1);
        chk("f23_done", frame_done, 1'b1);
        chk("f23_kept", frame_kept, 4'd8);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // mask and saturation, back-to-back frame boundary
    for (int i = 0; i < 8; i++) step(1'b1, v24[i], k24[i], 1'b1, 1'b1);
    chk("f24_sat", sat_count, 8'd1);
    chk("f24_kept", frame_kept, 4'd3);

    // backpressure mid-frame
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'(i), 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // mode latch: ena drops at element 3, frame stays scaled; next frame bypass
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h21 + i), 1'b1, (i < 3), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h90 + i), 1'(i & 1), 1'b0, 1'b1);
    chk("mode_bypass_kept", frame_kept, 4'd8);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(9, 0) < 7), 8'($urandom), 1'($urandom), ($urandom_range(15, 0) != 0),
           ($urandom_range(9, 0) < 7));
    end
    for (int n = 0; n < 3; n++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // reset mid-frame after element 5
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h11 * i), 1'b1, 1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h01 + i), 1'b1, 1'b1, 1'b1);
      if (i == 7) begin
        chk("rst_frame_last", out_last, 1'b1);
        chk("rst_frame_done", frame_done, 1'b1);
      end
    end

    // clip counter saturates at 255
    for (int i = 0; i < 300; i++) step(1'b1, 8'hC0, 1'b1, 1'b1, 1'b1);
    chk("sat_255", sat_count, 8'd255);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("sat_hold", sat_count, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
